// File: rtl/res_top.sv
// rtl/res_top.sv - 16-neuron echo-state reservoir core with two lockstep serial MAC PEs (optional RES_LEAK_EN leaky commit)
module res_pe #(
  parameter int DW    = 8,
  parameter int FRAC  = 7,
  parameter int ACC_W = 20
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 mac_en,
  input  logic                 mac_first,
  input  logic [3:0]           n,
  input  logic [3:0]           j,
  input  logic signed [DW-1:0] data,
  output logic signed [DW-1:0] f
);
  logic signed [DW-1:0]     DATA;
  logic signed [DW-1:0]     WEIGHT;
  logic [4:0]               w_raw;
  logic [4:0]               w_off;
  logic signed [2*DW-1:0]   prod;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic signed [ACC_W-1:0]  r;

  assign DATA = data;

  // W[n][j] = ((7n + 13j) mod 32) - 16; flipping bit 4 of the 5-bit residue subtracts 16
  always_comb begin
    w_raw  = {1'b0, n} * 5'd7 + {1'b0, j} * 5'd13;
    w_off  = w_raw ^ 5'b10000;
    WEIGHT = {{(DW-5){w_off[4]}}, w_off};
  end

  always_comb begin
    prod  = DATA * WEIGHT;
    acc_d = acc_q;
    if (mac_en) begin
      acc_d = mac_first ? ACC_W'(prod) : acc_q + ACC_W'(prod);
    end
  end

  // floor rescale, then hard-tanh clamp to the Q1.7 range
  always_comb begin
    r = acc_q >>> FRAC;
    if (r > 20'sd127) begin
      f = 8'sh7F;
    end else if (r < -20'sd128) begin
      f = -8'sd128;
    end else begin
      f = r[DW-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end
endmodule

module res_top #(
  parameter int N_NEURON = 16,
  parameter int DW       = 8,
  parameter int FRAC     = 7,
  parameter int ACC_W    = 20
) (
  input  logic                   clk,
  input  logic                   rst_N,
  output logic [N_NEURON*DW-1:0] xstate
);
  localparam logic [N_NEURON*DW-1:0] XRST = {{(N_NEURON*DW-8){1'b0}}, 8'h40};

  logic [4:0]               c_q, c_d;
  logic [2:0]               k_q, k_d;
  logic [N_NEURON*DW-1:0]   xstate_q, xstate_d;
  logic [N_NEURON*DW-1:0]   nbuf_q, nbuf_d;
  logic                     mac_en, mac_first, wr_en, commit;
  logic [3:0]               j_idx;
  logic signed [DW-1:0]     src;
  logic signed [DW-1:0]     f0, f1;
  logic signed [DW-1:0]     x_old, f_new;

  always_comb begin
    mac_en    = (c_q != 5'd16);
    mac_first = (c_q == 5'd0);
    wr_en     = (c_q == 5'd16);
    commit    = wr_en && (k_q == 3'd7);
    j_idx     = c_q[3:0];
    src       = xstate_q[{j_idx, 3'b000} +: DW];
    c_d       = wr_en ? 5'd0 : c_q + 5'd1;
    k_d       = wr_en ? k_q + 3'd1 : k_q;
  end

  res_pe #(.DW(DW), .FRAC(FRAC), .ACC_W(ACC_W)) PE0 (
    .clk(clk), .rst(rst_N), .mac_en(mac_en), .mac_first(mac_first),
    .n({1'b0, k_q}), .j(j_idx), .data(src), .f(f0)
  );

  res_pe #(.DW(DW), .FRAC(FRAC), .ACC_W(ACC_W)) PE1 (
    .clk(clk), .rst(rst_N), .mac_en(mac_en), .mac_first(mac_first),
    .n({1'b1, k_q}), .j(j_idx), .data(src), .f(f1)
  );

  // commit reads nbuf_d so the two results written in this same cycle are included
  always_comb begin
    nbuf_d   = nbuf_q;
    xstate_d = xstate_q;
    x_old    = '0;
    f_new    = '0;
    if (wr_en) begin
      nbuf_d[{1'b0, k_q, 3'b000} +: DW] = f0;
      nbuf_d[{1'b1, k_q, 3'b000} +: DW] = f1;
    end
    if (commit) begin
      for (int i = 0; i < N_NEURON; i++) begin
        x_old = xstate_q[i*DW +: DW];
        f_new = nbuf_d[i*DW +: DW];
`ifdef RES_LEAK_EN
        xstate_d[i*DW +: DW] = (x_old >>> 1) + (f_new >>> 1);
`else
        xstate_d[i*DW +: DW] = f_new;
`endif
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst_N) begin
      c_q      <= '0;
      k_q      <= '0;
      nbuf_q   <= '0;
      xstate_q <= XRST;
    end else begin
      c_q      <= c_d;
      k_q      <= k_d;
      nbuf_q   <= nbuf_d;
      xstate_q <= xstate_d;
    end
  end

  assign xstate = xstate_q;
endmodule

// File: tb/tb_res_top.sv
// tb/tb_res_top.sv - directed self-checking bench for res_top against a behavioural reservoir model
module tb_res_top;
  localparam logic [127:0] RST_X = 128'h40;

  logic         clk;
  logic         rst_N;
  logic [127:0] xstate;

  int           checks;
  int           errors;
  int           ecnt;
  logic [127:0] m_state;
  int           raw_r [16];

  res_top dut (.clk(clk), .rst_N(rst_N), .xstate(xstate));

  initial begin
    clk = 1'b0;
    forever #1 clk = ~clk;
  end

  task automatic model_step();
    logic [127:0] nx;
    int acc, r, f, xo, w, nv;
    nx = '0;
    for (int n = 0; n < 16; n++) begin
      acc = 0;
      for (int j = 0; j < 16; j++) begin
        w   = ((7 * n + 13 * j) % 32) - 16;
        acc = acc + $signed(m_state[j*8 +: 8]) * w;
      end
      r = acc >>> 7;
      raw_r[n] = r;
      f = (r > 127) ? 127 : ((r < -128) ? -128 : r);
      xo = $signed(m_state[n*8 +: 8]);
`ifdef RES_LEAK_EN
      nv = (xo >>> 1) + (f >>> 1);
`else
      nv = f + 0 * xo;
`endif
      nx[n*8 +: 8] = 8'(nv);
    end
    m_state = nx;
  endtask

  task automatic test_reset();
    rst_N = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      @(negedge clk);
      checks++;
      if (xstate !== RST_X) begin
        errors++;
        $display("FAIL reset_state cycle=%0d got=%h exp=%h", i, xstate, RST_X);
      end
    end
    rst_N   = 1'b0;
    ecnt    = 0;
    m_state = RST_X;
  endtask

  task automatic test_first_update();
    for (int e = 0; e < 136; e++) begin
      @(posedge clk);
      ecnt++;
      if (ecnt % 136 == 0) model_step();
      @(negedge clk);
      checks++;
      if (xstate !== m_state) begin
        errors++;
        $display("FAIL first_update edge=%0d got=%h exp=%h", ecnt, xstate, m_state);
      end
    end
`ifndef RES_LEAK_EN
    checks++;
    if (xstate[31:0] !== 32'h02FFFBF8) begin
      errors++;
      $display("FAIL first_update_bytes got=%h exp=%h", xstate[31:0], 32'h02FFFBF8);
    end
`endif
  endtask

  task automatic test_stability();
    for (int e = 0; e < 13 * 136; e++) begin
      @(posedge clk);
      ecnt++;
      if (ecnt % 136 == 0) model_step();
      @(negedge clk);
      checks++;
      if (xstate !== m_state) begin
        errors++;
        $display("FAIL stability edge=%0d got=%h exp=%h", ecnt, xstate, m_state);
      end
    end
  endtask

  task automatic test_saturation();
    logic [7:0] b;
    for (int e = 0; e < 1000; e++) begin
      @(posedge clk);
      ecnt++;
      if (ecnt % 136 == 0) model_step();
      @(negedge clk);
      checks++;
      if (xstate !== m_state) begin
        errors++;
        $display("FAIL saturation_model edge=%0d got=%h exp=%h", ecnt, xstate, m_state);
      end
`ifndef RES_LEAK_EN
      if (ecnt % 136 == 0) begin
        for (int n = 0; n < 16; n++) begin
          b = xstate[n*8 +: 8];
          if (raw_r[n] > 127) begin
            checks++;
            if (b !== 8'h7F) begin
              errors++;
              $display("FAIL saturation_pos neuron=%0d got=%h exp=7f", n, b);
            end
          end else if (raw_r[n] < -128) begin
            checks++;
            if (b !== 8'h80) begin
              errors++;
              $display("FAIL saturation_neg neuron=%0d got=%h exp=80", n, b);
            end
          end
        end
      end
`endif
    end
  endtask

  task automatic test_mid_reset();
    while (ecnt % 136 != 70) begin
      @(posedge clk);
      ecnt++;
      if (ecnt % 136 == 0) model_step();
      @(negedge clk);
      checks++;
      if (xstate !== m_state) begin
        errors++;
        $display("FAIL mid_reset_pre edge=%0d got=%h exp=%h", ecnt, xstate, m_state);
      end
    end
    rst_N = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (xstate !== RST_X) begin
      errors++;
      $display("FAIL mid_reset_state got=%h exp=%h", xstate, RST_X);
    end
    rst_N   = 1'b0;
    ecnt    = 0;
    m_state = RST_X;
    for (int e = 0; e < 136; e++) begin
      @(posedge clk);
      ecnt++;
      if (ecnt % 136 == 0) model_step();
      @(negedge clk);
      checks++;
      if (xstate !== m_state) begin
        errors++;
        $display("FAIL mid_reset_post edge=%0d got=%h exp=%h", ecnt, xstate, m_state);
      end
    end
`ifndef RES_LEAK_EN
    checks++;
    if (xstate[7:0] !== 8'hF8) begin
      errors++;
      $display("FAIL mid_reset_neuron0 got=%h exp=f8", xstate[7:0]);
    end
`endif
  endtask

  initial begin
    checks = 0;
    errors = 0;
    ecnt   = 0;
    rst_N  = 1'b1;
    m_state = RST_X;
    test_reset();
    test_first_update();
    test_stability();
    test_saturation();
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
